cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
Sequencing controller for the 2-way, 128-set, one-word-per-line cache array. It accepts CPU load/store requests and performs tag lookup through the array's hit/valid outputs. It handles misses by fetching from main memory and chooses the fill way with a per-set LRU bit. Policy is write-through, no-write-allocate. It sits between the CPU memory stage and the cache array / main-memory port, and also keeps hit/miss statistics.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data word width
SET_BITS, 7, set index width (128 sets); set = addr[SET_BITS+1:2]
CNT_W, 16, width of hit/miss counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
cpu_req  in  1  request; held with addr/data stable until cpu_ready
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_W  word address (bits [1:0] ignored)
cpu_wdata  in  DATA_W  store data
cpu_rdata  out  DATA_W  load data, registered, valid with cpu_ready
cpu_ready  out  1  one-cycle completion pulse
cpu_busy  out  1  high whenever state != IDLE
arr_addr  out  ADDR_W  latched request address driven to array
arr_hit0  in  1  way0 valid and tag match for arr_addr
arr_hit1  in  1  way1 valid and tag match for arr_addr
arr_valid0  in  1  way0 valid bit of indexed set
arr_valid1  in  1  way1 valid bit of indexed set
arr_rdata  in  DATA_W  array read data (way1 priority on double hit)
arr_we  out  1  one-cycle array write strobe
arr_way  out  1  way to write
arr_wdata  out  DATA_W  data/tag-source for array write
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, one cycle
hit_count  out  CNT_W  saturating lookup-hit count
miss_count  out  CNT_W  saturating lookup-miss count

Behaviour:
- Reset (rst=1 at edge): state IDLE. cpu_ready, cpu_busy, arr_we, mem_req, mem_we = 0. cpu_rdata, mem_addr, mem_wdata, arr_addr, counters = 0. All 128 LRU bits = 0. Any in-flight request is discarded; a later mem_ack is ignored.
- States: IDLE, LOOKUP, MEM_RD, FILL, MEM_WR.
- IDLE: if cpu_req, latch addr/we/wdata and go to LOOKUP. Otherwise stay in IDLE. cpu_req while busy is not sampled.
- LOOKUP (1 cycle), hit = arr_hit0|arr_hit1, hit way = 1 if arr_hit1 else 0:
  - Read hit: cpu_rdata <= arr_rdata; cpu_ready pulses next cycle; lru[set] <= ~hitway; hit_count+1; go to IDLE. Total latency is 2 cycles from the accept edge to cpu_ready high.
  - Read miss: miss_count+1; go to MEM_RD.
  - Write hit: arr_we=1, arr_way=hitway, arr_wdata=wdata for this cycle; lru[set] <= ~hitway; hit_count+1; go to MEM_WR.
  - Write miss: miss_count+1; no array write; go to MEM_WR.
- MEM_RD: mem_req=1, mem_we=0, mem_addr=latched addr. On mem_ack (including in the first cycle), capture mem_rdata and go to FILL.
- FILL (1 cycle): victim = 0 if !arr_valid0, else 1 if !arr_valid1, else lru[set]. arr_we=1, arr_way=victim, arr_wdata=captured data. cpu_rdata <= captured data; cpu_ready pulses next cycle; lru[set] <= ~victim; go to IDLE.
- MEM_WR: mem_req=1, mem_we=1, mem_wdata=latched wdata. On mem_ack, pulse cpu_ready and go to IDLE.
- mem_req deasserts on the edge after mem_ack. mem_ack outside MEM_RD/MEM_WR is ignored.
- Counters saturate at all-ones. A reset clears them.
- arr_we is never high for more than one consecutive cycle per request.

Test Plan:
- Cold read miss: reset, read 0x0000_0104, both valid=0, mem_ack after 3 cycles with 0xDEADBEEF -> mem_addr=0x104, arr_we pulse way0, cpu_rdata=0xDEADBEEF with cpu_ready, miss_count=1.
- Read hit: re-read 0x104 with arr_hit0=1, arr_rdata=0xDEADBEEF -> cpu_ready 2 cycles after accept, mem_req never high, hit_count=1, lru[0x41]=1.
- LRU replacement: fill 0x304 into way1, hit 0x104 (way0), then read-miss 0x504 with both valid -> FILL writes arr_way=1.
- Write hit: store 0x12345678 to 0x104, arr_hit0=1 -> single arr_we on way0; mem_we=1, mem_wdata=0x12345678 until ack; then cpu_ready.
- Write miss: store to 0x904, no hits -> arr_we stays 0, memory write completes, miss_count+1.
- Reset mid-miss: assert rst during MEM_RD -> next cycle IDLE, mem_req=0, counters 0; mem_ack one cycle later produces no cpu_ready and no arr_we.

Source files
------------

// File: rtl/cache_ctrl.sv
// cache_ctrl: sequencing controller for a 2-way, 128-set, one-word-per-line
// write-through / no-write-allocate cache.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cpu_*               CPU request side. Handshake: the CPU raises cpu_req
//                       with cpu_we/cpu_addr/cpu_wdata stable and holds them
//                       until cpu_ready (a one-cycle pulse, registered) is
//                       seen; cpu_rdata is valid in the cpu_ready cycle.
//                       cpu_busy is high whenever the controller is not idle.
//   arr_*               cache array: arr_addr indexes the array, hit/valid
//                       and rdata come back combinationally; arr_we is a
//                       one-cycle write strobe into way arr_way.
//   mem_*               main memory: mem_req (with mem_we/addr/wdata) is held
//                       until the one-cycle mem_ack; mem_rdata valid with ack.
//   hit_count/miss_count saturating lookup statistics.
module cache_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SET_BITS = 7,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_busy,
  output logic [ADDR_W-1:0] arr_addr,
  input  logic              arr_hit0,
  input  logic              arr_hit1,
  input  logic              arr_valid0,
  input  logic              arr_valid1,
  input  logic [DATA_W-1:0] arr_rdata,
  output logic              arr_we,
  output logic              arr_way,
  output logic [DATA_W-1:0] arr_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MEM_RD = 3'd2,
    FILL   = 3'd3,
    MEM_WR = 3'd4
  } state_t;

  localparam int NSETS = 1 << SET_BITS;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t              state, state_nx;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W-1:0]   fill_data;
  // lru[s] names the way to evict next in set s.
  logic [NSETS-1:0]    lru;
  logic [SET_BITS-1:0] set_idx;
  logic                hit;
  logic                hit_way;
  logic                victim;

  assign set_idx = req_addr[SET_BITS+1:2];
  assign hit     = arr_hit0 | arr_hit1;
  assign hit_way = arr_hit1;
  // Empty ways are filled before anything is evicted.
  assign victim  = !arr_valid0 ? 1'b0 : (!arr_valid1 ? 1'b1 : lru[set_idx]);

  // The latched request drives both the array index and the memory port.
  assign arr_addr  = req_addr;
  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;
  assign cpu_busy  = (state != IDLE);
  assign mem_req   = (state == MEM_RD) || (state == MEM_WR);
  assign mem_we    = (state == MEM_WR);

  always_comb begin
    state_nx  = state;
    arr_we    = 1'b0;
    arr_way   = 1'b0;
    arr_wdata = req_wdata;
    case (state)
      IDLE:   if (cpu_req) state_nx = LOOKUP;
      LOOKUP: begin
        if (hit) begin
          if (req_we) begin
            arr_we   = 1'b1;
            arr_way  = hit_way;
            state_nx = MEM_WR;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          state_nx = req_we ? MEM_WR : MEM_RD;
        end
      end
      MEM_RD: if (mem_ack) state_nx = FILL;
      FILL: begin
        arr_we    = 1'b1;
        arr_way   = victim;
        arr_wdata = fill_data;
        state_nx  = IDLE;
      end
      MEM_WR: if (mem_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      fill_data  <= '0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      lru        <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state     <= state_nx;
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (hit_count != '1) hit_count <= hit_count + CNT_ONE;
            lru[set_idx] <= ~hit_way;
            if (!req_we) begin
              cpu_rdata <= arr_rdata;
              cpu_ready <= 1'b1;
            end
          end else begin
            if (miss_count != '1) miss_count <= miss_count + CNT_ONE;
          end
        end
        MEM_RD: if (mem_ack) fill_data <= mem_rdata;
        FILL: begin
          cpu_rdata    <= fill_data;
          cpu_ready    <= 1'b1;
          lru[set_idx] <= ~victim;
        end
        MEM_WR: if (mem_ack) cpu_ready <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Testbench for cache_ctrl. The bench plays the cache array (tag/valid/data
// store indexed by arr_addr) and main memory, and predicts every transaction
// from cache-level rules: loads return the last value stored to the address,
// fills go to an empty way or else the least-recently-used way, stores are
// written through and only update the array on a hit.
module tb_cache_ctrl;
  localparam int AW = 32, DW = 32, SB = 7, CW = 16;
  localparam int NS = 1 << SB;
  localparam int TW = AW - SB - 2;

  logic          clk, rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_ready, cpu_busy;
  logic [AW-1:0] arr_addr;
  logic          arr_hit0, arr_hit1, arr_valid0, arr_valid1;
  logic [DW-1:0] arr_rdata;
  logic          arr_we, arr_way;
  logic [DW-1:0] arr_wdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
  logic [CW-1:0] hit_count, miss_count;

  cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SET_BITS(SB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy),
    .arr_addr(arr_addr), .arr_hit0(arr_hit0), .arr_hit1(arr_hit1),
    .arr_valid0(arr_valid0), .arr_valid1(arr_valid1), .arr_rdata(arr_rdata),
    .arr_we(arr_we), .arr_way(arr_way), .arr_wdata(arr_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // array emulation
  logic          v_m [2][NS];
  logic [TW-1:0] t_m [2][NS];
  logic [DW-1:0] d_m [2][NS];
  logic [SB-1:0] a_set;
  logic [TW-1:0] a_tag;

  always_comb begin
    a_set      = arr_addr[SB+1:2];
    a_tag      = arr_addr[AW-1:SB+2];
    arr_valid0 = v_m[0][a_set];
    arr_valid1 = v_m[1][a_set];
    arr_hit0   = v_m[0][a_set] && (t_m[0][a_set] == a_tag);
    arr_hit1   = v_m[1][a_set] && (t_m[1][a_set] == a_tag);
    arr_rdata  = arr_hit1 ? d_m[1][a_set] : d_m[0][a_set];
  end

  // memory and reference state
  logic [DW-1:0] mem_m [logic [AW-1:0]];
  logic          evict_ref [NS];   // way to evict next when both ways valid
  int            exp_hits, exp_miss;
  int            total, bad;
  logic [DW-1:0] last_rdata;
  logic          last_way;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {a[15:0], ~a[15:0]} ^ 32'h3C5A_96E1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CPU transaction, d = memory ack delay in cycles of mem_req (>=1).
  task automatic run_txn(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int d);
    logic [SB-1:0] set;
    logic [TW-1:0] tag;
    logic          h0, h1, hit, vic;
    logic [DW-1:0] memv;
    int            exp_wcnt, exp_mcnt, exp_lat;
    logic          exp_way;
    logic [DW-1:0] exp_wdata;
    int            cyc, wcnt, mcnt, lat;
    logic          done, pend, w_way, m_we;
    logic [DW-1:0] w_data, m_wdata, got_rd;
    logic [AW-1:0] m_addr, w_addr;

    set  = addr[SB+1:2];
    tag  = addr[AW-1:SB+2];
    h0   = v_m[0][set] && (t_m[0][set] == tag);
    h1   = v_m[1][set] && (t_m[1][set] == tag);
    hit  = h0 | h1;
    memv = mem_val(addr);
    exp_way = 1'b0; exp_wdata = '0; exp_wcnt = 0; exp_mcnt = 0; exp_lat = 2;
    if (hit) begin
      exp_hits++;
      evict_ref[set] = ~h1;
      if (we) begin
        exp_wcnt = 1; exp_way = h1; exp_wdata = wd; exp_mcnt = d; exp_lat = 2 + d;
      end
    end else begin
      exp_miss++;
      exp_mcnt = d;
      if (we) begin
        exp_lat = 2 + d;
      end else begin
        vic = !v_m[0][set] ? 1'b0 : (!v_m[1][set] ? 1'b1 : evict_ref[set]);
        evict_ref[set] = ~vic;
        exp_wcnt = 1; exp_way = vic; exp_wdata = memv; exp_lat = 3 + d;
      end
    end

    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    cyc = 0; wcnt = 0; mcnt = 0; lat = 0; done = 1'b0; pend = 1'b0;
    w_way = 1'b0; w_data = '0; w_addr = '0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    got_rd = '0;
    while (!done && cyc < 60) begin
      @(posedge clk);
      if (pend) begin
        v_m[w_way][w_addr[SB+1:2]] = 1'b1;
        t_m[w_way][w_addr[SB+1:2]] = w_addr[AW-1:SB+2];
        d_m[w_way][w_addr[SB+1:2]] = w_data;
        pend = 1'b0;
      end
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      if (cyc == 1) begin
        chk("busy_lookup", {31'd0, cpu_busy}, 32'd1);
        chk("arr_addr", arr_addr, addr);
      end
      if (cpu_ready) begin
        done = 1'b1; lat = cyc; got_rd = cpu_rdata; cpu_req = 1'b0;
      end
      if (arr_we) begin
        wcnt++; w_way = arr_way; w_data = arr_wdata; w_addr = arr_addr; pend = 1'b1;
      end
      if (mem_req) begin
        mcnt++;
        if (mcnt == 1) begin m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata; end
        if (mcnt == d) begin mem_ack = 1'b1; mem_rdata = we ? $urandom : memv; end
      end
    end
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    chk("ready_in_budget", {31'd0, done}, 32'd1);
    chk("latency", lat, exp_lat);
    chk("arr_we_count", wcnt, exp_wcnt);
    chk("mem_req_cycles", mcnt, exp_mcnt);
    if (!we) chk("load_data", got_rd, memv);
    if (exp_wcnt == 1) begin
      chk("arr_way", {31'd0, w_way}, {31'd0, exp_way});
      chk("arr_wdata", w_data, exp_wdata);
    end
    if (exp_mcnt > 0) begin
      chk("mem_we", {31'd0, m_we}, {31'd0, we});
      chk("mem_addr", m_addr, addr);
      if (we) chk("mem_wdata", m_wdata, wd);
    end
    chk("hit_count", {16'd0, hit_count}, exp_hits);
    chk("miss_count", {16'd0, miss_count}, exp_miss);
    if (we) mem_m[addr] = wd;
    last_rdata = got_rd;
    last_way   = w_way;
  endtask

  initial begin
    int rdy_seen, we_seen;
    total = 0; bad = 0; exp_hits = 0; exp_miss = 0;
    for (int i = 0; i < NS; i++) begin
      v_m[0][i] = 1'b0; v_m[1][i] = 1'b0;
      t_m[0][i] = '0;   t_m[1][i] = '0;
      d_m[0][i] = '0;   d_m[1][i] = '0;
      evict_ref[i] = 1'b0;
    end
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_busy", {31'd0, cpu_busy}, 32'd0);
    chk("rst_arr_we", {31'd0, arr_we}, 32'd0);
    chk("rst_mem_req", {30'd0, mem_req, mem_we}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_addr", arr_addr | mem_addr | mem_wdata, 32'd0);
    chk("rst_counts", {hit_count, miss_count}, 32'd0);
    rst = 1'b0;

    // directed sequence on set 0x41
    mem_m[32'h104] = 32'hDEAD_BEEF;
    run_txn(1'b0, 32'h104, 32'd0, 3);           // cold miss -> way0
    chk("cold_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("cold_way", {31'd0, last_way}, 32'd0);
    run_txn(1'b0, 32'h104, 32'd0, 1);           // hit
    run_txn(1'b0, 32'h304, 32'd0, 2);           // miss -> way1 (empty)
    run_txn(1'b0, 32'h104, 32'd0, 1);           // hit way0, way1 becomes LRU
    run_txn(1'b0, 32'h504, 32'd0, 1);           // both valid -> evict way1
    chk("lru_fill_way", {31'd0, last_way}, 32'd1);
    run_txn(1'b1, 32'h104, 32'h1234_5678, 2);   // write hit
    run_txn(1'b1, 32'h904, 32'hCAFE_F00D, 3);   // write miss
    run_txn(1'b0, 32'h104, 32'd0, 1);           // reads back stored value
    chk("store_readback", last_rdata, 32'h1234_5678);

    // reset during MEM_RD
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hA04;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, cpu_busy}, 32'd0);
    chk("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_counts", {hit_count, miss_count}, 32'd0);
    exp_hits = 0; exp_miss = 0;
    for (int i = 0; i < NS; i++) evict_ref[i] = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    rdy_seen = 0; we_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      rdy_seen += int'(cpu_ready);
      we_seen  += int'(arr_we);
    end
    chk("stale_ack_ready", rdy_seen, 0);
    chk("stale_ack_arr_we", we_seen, 0);

    // randomized traffic over a few sets and tags
    for (int n = 0; n < 150; n++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 3) << (SB + 2)) | (($urandom_range(0, 3) + 32'h40) << 2);
      run_txn($urandom_range(0, 3) == 0, a, $urandom, $urandom_range(1, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
